// File: rtl/prime_trial_sched.sv
// ============================================================================
// prime_trial_sched : trial-division primality sequencer driving a shared divider
// Rev 1.0
// ============================================================================
`default_nettype none

module prime_trial_sched #(
  parameter int WIDTH = 1024,
  parameter int CNT_W = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_n,
  input  logic             abort,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_ready,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             busy,
  output logic             res_valid,
  output logic             res_prime,
  output logic             res_aborted,
  output logic [WIDTH-1:0] res_factor,
  output logic [CNT_W-1:0] res_trials
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_EVAL   = 3'd4,
    S_DRAIN  = 3'd5,
    S_REPORT = 3'd6
  } state_t;

  state_t             r_state, w_state;
  logic [WIDTH-1:0]   r_n, w_n;
  logic [WIDTH-1:0]   r_d, w_d;
  logic [WIDTH-1:0]   r_q, w_q;
  logic [WIDTH-1:0]   r_r, w_r;
  logic [CNT_W-1:0]   r_trials, w_trials;
  logic               r_abort, w_abort;
  logic               r_prime, w_prime;
  logic               r_aborted, w_aborted;
  logic [WIDTH-1:0]   r_factor, w_factor;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= S_IDLE;
      r_n       <= '0;
      r_d       <= '0;
      r_q       <= '0;
      r_r       <= '0;
      r_trials  <= '0;
      r_abort   <= 1'b0;
      r_prime   <= 1'b0;
      r_aborted <= 1'b0;
      r_factor  <= '0;
    end else begin
      r_state   <= w_state;
      r_n       <= w_n;
      r_d       <= w_d;
      r_q       <= w_q;
      r_r       <= w_r;
      r_trials  <= w_trials;
      r_abort   <= w_abort;
      r_prime   <= w_prime;
      r_aborted <= w_aborted;
      r_factor  <= w_factor;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_n       = r_n;
    w_d       = r_d;
    w_q       = r_q;
    w_r       = r_r;
    w_trials  = r_trials;
    w_abort   = r_abort;
    w_prime   = r_prime;
    w_aborted = r_aborted;
    w_factor  = r_factor;
    div_start = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_n       = cmd_n;
          w_d       = WIDTH'(2);
          w_trials  = '0;
          w_abort   = 1'b0;
          w_prime   = 1'b0;
          w_aborted = 1'b0;
          w_factor  = '0;
          w_state   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (r_n < WIDTH'(2)) begin
          w_prime  = 1'b0;
          w_factor = '0;
          w_state  = S_REPORT;
        end else begin
          w_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Abort wins over a same-cycle start so no division is left orphaned.
        if (abort) begin
          w_aborted = 1'b1;
          w_state   = S_REPORT;
        end else if (div_ready) begin
          div_start = 1'b1;
          w_state   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          w_abort = 1'b1;
        end
        if (div_done) begin
          w_q      = div_quotient;
          w_r      = div_remainder;
          w_trials = (&r_trials) ? r_trials : r_trials + CNT_W'(1);
          w_state  = (r_abort || abort) ? S_DRAIN : S_EVAL;
        end
      end
      S_EVAL: begin
        // q < d means d*d > N, so no smaller factor remains untested.
        if ((r_r == '0) && (r_d != r_n)) begin
          w_factor = r_d;
          w_prime  = 1'b0;
          w_state  = S_REPORT;
        end else if (r_q < r_d) begin
          w_factor = '0;
          w_prime  = 1'b1;
          w_state  = S_REPORT;
        end else if (abort) begin
          w_aborted = 1'b1;
          w_state   = S_REPORT;
        end else begin
          w_d     = (r_d == WIDTH'(2)) ? WIDTH'(3) : r_d + WIDTH'(2);
          w_state = S_ISSUE;
        end
      end
      S_DRAIN: begin
        w_aborted = 1'b1;
        w_state   = S_REPORT;
      end
      S_REPORT: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign res_valid    = (r_state == S_REPORT);
  assign div_dividend = r_n;
  assign div_divisor  = r_d;
  assign res_prime    = r_prime;
  assign res_aborted  = r_aborted;
  assign res_factor   = r_factor;
  assign res_trials   = r_trials;

endmodule

`default_nettype wire

// File: tb/tb_prime_trial_sched.sv
// Directed bench for prime_trial_sched with a fixed-latency divider model.
`default_nettype none

module tb_prime_trial_sched;

  localparam int W   = 16;
  localparam int CW  = 32;
  localparam int LAT = 2 * W + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid, cmd_ready, abort;
  logic [W-1:0]  cmd_n;
  logic          div_start, div_ready, div_done;
  logic [W-1:0]  div_dividend, div_divisor, div_quotient, div_remainder;
  logic          busy, res_valid, res_prime, res_aborted;
  logic [W-1:0]  res_factor;
  logic [CW-1:0] res_trials;

  always #5 clk = ~clk;

  prime_trial_sched #(.WIDTH(W), .CNT_W(CW)) dut (
    .sys_clk       (clk),
    .sys_rst       (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_n         (cmd_n),
    .abort         (abort),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_ready     (div_ready),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .busy          (busy),
    .res_valid     (res_valid),
    .res_prime     (res_prime),
    .res_aborted   (res_aborted),
    .res_factor    (res_factor),
    .res_trials    (res_trials)
  );

  // Divider model: same start/ready/done timing as the restoring divider.
  logic          dv_busy;
  int            dv_cnt;
  logic [W-1:0]  dv_a, dv_b;
  assign div_ready = !dv_busy;

  always @(posedge clk) begin
    if (rst) begin
      dv_busy       <= 1'b0;
      dv_cnt        <= 0;
      dv_a          <= '0;
      dv_b          <= '0;
      div_done      <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else begin
      div_done <= 1'b0;
      if (!dv_busy && div_start) begin
        dv_busy <= 1'b1;
        dv_cnt  <= LAT - 1;
        dv_a    <= div_dividend;
        dv_b    <= div_divisor;
      end else if (dv_busy) begin
        if (dv_cnt == 0) begin
          dv_busy       <= 1'b0;
          div_done      <= 1'b1;
          div_quotient  <= dv_a / dv_b;
          div_remainder <= dv_a % dv_b;
        end else begin
          dv_cnt <= dv_cnt - 1;
        end
      end
    end
  end

  int starts = 0;
  always @(posedge clk) if (div_start) starts <= starts + 1;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic         got_prime, got_abort, got_tmo;
  logic [W-1:0] got_factor;
  int           got_trials, got_cyc, got_starts;

  task automatic send(input logic [W-1:0] n);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    cmd_valid = 1'b1;
    cmd_n     = n;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [W-1:0] n, input int abort_at);
    int  base, cyc;
    bit  sent;
    sent    = 0;
    cyc     = 0;
    got_tmo = 1'b0;
    base    = starts;
    send(n);
    forever begin
      @(negedge clk);
      cyc++;
      if (abort) abort = 1'b0;
      if (abort_at > 0 && !sent && (starts - base) == abort_at) begin
        abort = 1'b1;
        sent  = 1;
      end
      if (res_valid) break;
      if (cyc > 3000) begin
        got_tmo = 1'b1;
        break;
      end
    end
    abort      = 1'b0;
    got_prime  = res_prime;
    got_abort  = res_aborted;
    got_factor = res_factor;
    got_trials = int'(res_trials);
    got_cyc    = cyc;
    got_starts = starts - base;
    check("timeout", got_tmo, 0);
  endtask

  initial begin
    int base, w;
    cmd_valid = 1'b0;
    cmd_n     = '0;
    abort     = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_div_start", div_start, 0);
    check("rst_trials", res_trials, 0);

    run_cmd(16'd2, 0);
    check("n2_prime", got_prime, 1);
    check("n2_factor", got_factor, 0);
    check("n2_trials", got_trials, 1);

    run_cmd(16'd91, 0);
    check("n91_prime", got_prime, 0);
    check("n91_factor", got_factor, 7);
    check("n91_trials", got_trials, 4);
    check("n91_starts", got_starts, 4);
    check("n91_aborted", got_abort, 0);

    run_cmd(16'd97, 0);
    check("n97_prime", got_prime, 1);
    check("n97_factor", got_factor, 0);
    check("n97_trials", got_trials, 6);
    check("n97_starts", got_starts, 6);

    run_cmd(16'd0, 0);
    check("n0_starts", got_starts, 0);
    check("n0_latency", got_cyc, 2);
    check("n0_prime", got_prime, 0);

    run_cmd(16'd1, 0);
    check("n1_starts", got_starts, 0);
    check("n1_latency", got_cyc, 2);
    check("n1_prime", got_prime, 0);

    run_cmd(16'd65521, 3);
    check("abort_flag", got_abort, 1);
    check("abort_trials", got_trials, 3);
    check("abort_starts", got_starts, 3);
    @(negedge clk);
    check("abort_cmd_ready", cmd_ready, 1);

    // Reset while a division is in flight.
    base = starts;
    send(16'd97);
    w = 0;
    while ((starts - base) < 1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (5) @(negedge clk);
    check("mid_busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_cmd_ready", cmd_ready, 1);
    check("mrst_div_start", div_start, 0);
    check("mrst_res_valid", res_valid, 0);
    check("mrst_trials", res_trials, 0);
    check("mrst_dividend", div_dividend, 0);
    check("mrst_divisor", div_divisor, 0);
    base = starts;
    @(negedge clk);
    check("mrst_no_start", starts - base, 0);

    run_cmd(16'd15, 0);
    check("n15_prime", got_prime, 0);
    check("n15_factor", got_factor, 3);
    check("n15_trials", got_trials, 2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
